fetch_unit: RTL

//  Parametrised instruction-fetch front end for the 5-stage RISC-V core; replaces the inline PC/IF logic.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 50 +++++
 rtl/fetch_unit_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
// MMU encodings, NOP encoding and fetch FSM state codes.
package fetch_unit_pkg;

  localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;
  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ  = 2'd1;
  localparam logic [1:0] FETCH_DROP = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: MMU read port, redirect and decode handshake.
// master = fetch unit, slave = MMU/pipeline environment.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  mmu_mem_ready;
  logic [31:0]           mmu_data_out;
  logic                  mmu_read_enable;
  logic [ADDR_WIDTH-1:0] mmu_address;
  logic [1:0]            mmu_mem_data_width;
  logic                  mmu_mem_signed_read;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;

  modport master (
    input  mmu_mem_ready,
    input  mmu_data_out,
    output mmu_read_enable,
    output mmu_address,
    output mmu_mem_data_width,
    output mmu_mem_signed_read,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    output mmu_mem_ready,
    output mmu_data_out,
    input  mmu_read_enable,
    input  mmu_address,
    input  mmu_mem_data_width,
    input  mmu_mem_signed_read,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Prefetch queue: synchronous FIFO of {instr, pc} entries.
// Flush wins over push and pop; pointers wrap naturally.
module fetch_unit_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, MMU read FSM and prefetch queue.
// A read is only issued once a queue slot is guaranteed for it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0] NOP_INSTR = RISCV_NOP
) (
  input logic          clk,
  input logic          reset_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = 32 + ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [ADDR_WIDTH-1:0] tgt_pc;
  logic                  re_q;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic [CW-1:0]         count;
  logic [CW-1:0]         cnt_pop;
  logic [CW-1:0]         cnt_push;
  logic [QW-1:0]         head;

  assign tgt_pc   = bus.redirect_pc & ALIGN;
  assign valid    = count != '0;
  assign pop      = valid && bus.instr_ready;
  assign cnt_pop  = count - (pop ? ONE_C : '0);
  assign cnt_push = cnt_pop + ONE_C;

  fetch_unit_queue #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({bus.mmu_data_out, fetch_pc}),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head      (head)
  );

  // Next state, next PC and push decision for the read FSM.
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    push    = 1'b0;
    unique case (1'b1)
      state == FETCH_IDLE: begin
        if (bus.redirect)
          pc_n = tgt_pc;
        else if (cnt_pop < DEPTH_C)
          state_n = FETCH_REQ;
      end
      state == FETCH_REQ: begin
        if (bus.redirect) begin
          pc_n    = tgt_pc;
          state_n = bus.mmu_mem_ready ? FETCH_REQ
                                      : FETCH_DROP;
        end else if (bus.mmu_mem_ready) begin
          push    = 1'b1;
          pc_n    = fetch_pc + STEP;
          state_n = (cnt_push < DEPTH_C) ? FETCH_REQ
                                         : FETCH_IDLE;
        end
      end
      state == FETCH_DROP: begin
        if (bus.redirect)
          pc_n = tgt_pc;
        if (bus.mmu_mem_ready)
          state_n = FETCH_IDLE;
      end
      default: state_n = FETCH_IDLE;
    endcase
  end

  // A squashed read keeps its address until the MMU completes it.
  assign addr_n = (state_n == FETCH_DROP) ? addr_q : pc_n;

  // FSM, PC and registered MMU request outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_VECTOR;
      addr_q   <= RESET_VECTOR;
      re_q     <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      addr_q   <= addr_n;
      re_q     <= state_n != FETCH_IDLE;
    end
  end

  assign bus.mmu_read_enable     = re_q;
  assign bus.mmu_address         = addr_q;
  assign bus.mmu_mem_data_width  = MMU_WIDTH_WORD;
  assign bus.mmu_mem_signed_read = 1'b0;

  assign bus.instr_valid = valid;
  assign bus.instr    = valid ? head[QW-1:ADDR_WIDTH]
                              : NOP_INSTR;
  assign bus.instr_pc = valid ? head[ADDR_WIDTH-1:0]
                              : '0;

endmodule
